// File: rtl/acev_pkg.sv
// Shared constants for the host command decoder: wire byte offsets, default
// match values, and the parser state encoding.
package acev_pkg;

  localparam logic [47:0] DEF_DST_MAC    = 48'h0245_5416_6843;
  localparam logic [15:0] DEF_ETHER_TYPE = 16'h005c;
  localparam logic [31:0] DEF_TAG_TRIG   = 32'h6769_7274;
  localparam logic [31:0] DEF_TAG_SLOW   = 32'h776F_6C73;
  localparam logic [31:0] DEF_TAG_RESUME = 32'h6D75_7372;

  localparam int OFF_DST  = 0;
  localparam int OFF_TYPE = 12;
  localparam int OFF_TAG  = 14;
  localparam int OFF_ARG  = 18;

  // Beat indices derived from byte offsets (4 wire bytes per beat).
  localparam logic [2:0] WORD_DST_LO = 3'(OFF_DST / 4);
  localparam logic [2:0] WORD_DST_HI = 3'(OFF_DST / 4 + 1);
  localparam logic [2:0] WORD_TYPE   = 3'(OFF_TYPE / 4);
  localparam logic [2:0] WORD_TAG_HI = 3'((OFF_TAG + 2) / 4);
  localparam logic [2:0] WORD_LAST   = 3'((OFF_ARG + 3) / 4);

  typedef logic [1:0] state_t;
  localparam state_t ST_RECV = 2'd0;
  localparam state_t ST_DROP = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/host_cmd_decoder_if.sv
// MAC receive AXI-stream bundle; the MAC drives it, the decoder only listens.
interface host_cmd_decoder_if;

  logic [31:0] RxTdata;
  logic [3:0]  RxTkeep;
  logic        RxTvalid;
  logic        RxTlast;
  logic        RxTuser;

  modport master (output RxTdata, RxTkeep, RxTvalid, RxTlast, RxTuser);
  modport slave  (input  RxTdata, RxTkeep, RxTvalid, RxTlast, RxTuser);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && count != {W{1'b1}})
      count <= count + W'(1);
  end

endmodule

// File: rtl/host_cmd_decoder.sv
// Parses host command frames off the MAC receive stream and commits a command
// pulse or status count only when the whole frame turns out good.
module host_cmd_decoder
  import acev_pkg::*;
#(
  parameter logic [47:0] DST_MAC    = DEF_DST_MAC,
  parameter logic [15:0] ETHER_TYPE = DEF_ETHER_TYPE,
  parameter logic [31:0] TAG_TRIG   = DEF_TAG_TRIG,
  parameter logic [31:0] TAG_SLOW   = DEF_TAG_SLOW,
  parameter logic [31:0] TAG_RESUME = DEF_TAG_RESUME,
  parameter int          CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  host_cmd_decoder_if.slave    rx,
  output logic                 IlaTrigger,
  output logic                 HostRequestSlowDown,
  output logic                 HostResume,
  output logic [31:0]          HostFiFoFillAmt,
  output logic [CNT_W-1:0]     GoodCmdCount,
  output logic [CNT_W-1:0]     BadFrameCount,
  output logic [CNT_W-1:0]     UnknownTagCount
);

  state_t      state;
  logic [2:0]  word_idx;
  logic        runt_q;
  logic [31:0] tag_q;
  logic [15:0] arg_lo_q;
  logic [31:0] arg_q;

  logic        mismatch;
  logic        runt_now;
  logic        cur_runt;
  logic [31:0] cur_arg;
  logic        decide;
  logic        early_end;
  logic        good_frame;
  logic        hit_trig;
  logic        hit_slow;
  logic        hit_resume;
  logic        good_inc;
  logic        bad_inc;
  logic        unk_inc;

  // When the tlast beat is also beat 5 the verdict is taken straight from
  // RECV, so the tail of the argument and runt flag come from the live beat.
  always_comb begin
    mismatch = 1'b0;
    case (word_idx)
      WORD_DST_LO: mismatch = rx.RxTdata != DST_MAC[31:0];
      WORD_DST_HI: mismatch = rx.RxTdata[15:0] != DST_MAC[47:32];
      WORD_TYPE:   mismatch = rx.RxTdata[15:0] != {ETHER_TYPE[7:0], ETHER_TYPE[15:8]};
      default:     mismatch = 1'b0;
    endcase

    runt_now   = runt_q | (rx.RxTkeep != 4'hF);
    cur_runt   = (state == ST_HOLD) ? runt_q : runt_now;
    cur_arg    = (state == ST_HOLD) ? arg_q : {rx.RxTdata[15:0], arg_lo_q};

    decide     = rx.RxTvalid && rx.RxTlast &&
                 ((state == ST_HOLD) ||
                  (state == ST_RECV && word_idx == WORD_LAST && !mismatch));
    early_end  = rx.RxTvalid && rx.RxTlast && state == ST_RECV &&
                 word_idx != WORD_LAST && !mismatch;

    good_frame = decide && !(rx.RxTuser || cur_runt);
    hit_trig   = good_frame && tag_q == TAG_TRIG;
    hit_slow   = good_frame && tag_q == TAG_SLOW;
    hit_resume = good_frame && tag_q == TAG_RESUME;

    good_inc   = hit_trig || hit_slow || hit_resume;
    unk_inc    = good_frame && !good_inc;
    bad_inc    = early_end || (decide && (rx.RxTuser || cur_runt));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_RECV;
      word_idx            <= '0;
      runt_q              <= 1'b0;
      tag_q               <= '0;
      arg_lo_q            <= '0;
      arg_q               <= '0;
      IlaTrigger          <= 1'b0;
      HostRequestSlowDown <= 1'b0;
      HostResume          <= 1'b0;
      HostFiFoFillAmt     <= '0;
    end else begin
      IlaTrigger          <= hit_trig;
      HostRequestSlowDown <= hit_slow;
      HostResume          <= hit_resume;
      if (hit_slow)
        HostFiFoFillAmt <= cur_arg;

      if (rx.RxTvalid) begin
        case (state)
          ST_RECV: begin
            if (word_idx == WORD_TYPE)
              tag_q[15:0] <= rx.RxTdata[31:16];
            if (word_idx == WORD_TAG_HI) begin
              tag_q[31:16] <= rx.RxTdata[15:0];
              arg_lo_q     <= rx.RxTdata[31:16];
            end
            if (rx.RxTlast || mismatch) begin
              state    <= rx.RxTlast ? ST_RECV : ST_DROP;
              word_idx <= '0;
              runt_q   <= 1'b0;
            end else if (word_idx == WORD_LAST) begin
              state  <= ST_HOLD;
              arg_q  <= {rx.RxTdata[15:0], arg_lo_q};
              runt_q <= runt_now;
            end else begin
              word_idx <= word_idx + 3'd1;
              runt_q   <= runt_now;
            end
          end
          ST_DROP, ST_HOLD: begin
            if (rx.RxTlast) begin
              state    <= ST_RECV;
              word_idx <= '0;
              runt_q   <= 1'b0;
            end
          end
          default: state <= ST_RECV;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_good (
    .clk(clk), .reset(reset), .inc(good_inc), .count(GoodCmdCount)
  );

  sat_counter #(.W(CNT_W)) u_bad (
    .clk(clk), .reset(reset), .inc(bad_inc), .count(BadFrameCount)
  );

  sat_counter #(.W(CNT_W)) u_unknown (
    .clk(clk), .reset(reset), .inc(unk_inc), .count(UnknownTagCount)
  );

endmodule

// File: tb/tb_host_cmd_decoder.sv
// Scoreboard bench: frames push their expected response, a negedge monitor
// pops and compares whenever a pulse fires or a counter moves.
module tb_host_cmd_decoder;
  import acev_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  host_cmd_decoder_if rx ();

  logic        IlaTrigger, HostRequestSlowDown, HostResume;
  logic [31:0] HostFiFoFillAmt;
  logic [15:0] GoodCmdCount, BadFrameCount, UnknownTagCount;

  logic        sm_trig, sm_slow, sm_resume;
  logic [31:0] sm_fill;
  logic [1:0]  sm_good, sm_bad, sm_unk;

  host_cmd_decoder dut (
    .clk(clk), .reset(reset), .rx(rx),
    .IlaTrigger(IlaTrigger), .HostRequestSlowDown(HostRequestSlowDown),
    .HostResume(HostResume), .HostFiFoFillAmt(HostFiFoFillAmt),
    .GoodCmdCount(GoodCmdCount), .BadFrameCount(BadFrameCount),
    .UnknownTagCount(UnknownTagCount)
  );

  // Narrow-counter copy on the same stream, so saturation is reachable quickly.
  host_cmd_decoder #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .rx(rx),
    .IlaTrigger(sm_trig), .HostRequestSlowDown(sm_slow),
    .HostResume(sm_resume), .HostFiFoFillAmt(sm_fill),
    .GoodCmdCount(sm_good), .BadFrameCount(sm_bad),
    .UnknownTagCount(sm_unk)
  );

  typedef enum int {K_NONE, K_TRIG, K_SLOW, K_RSUM, K_BAD, K_UNK} kind_t;

  typedef struct {
    int          cyc;
    logic [2:0]  pulses;
    logic [31:0] fill;
    logic [15:0] good;
    logic [15:0] bad;
    logic [15:0] unk;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  logic [31:0] m_fill = '0;
  logic [15:0] m_good = '0, m_bad = '0, m_unk = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic push_expect(input kind_t k, input logic [31:0] arg);
    exp_t e;
    logic [2:0] p;
    p = 3'b000;
    case (k)
      K_TRIG: begin p = 3'b100; m_good = sat_inc(m_good); end
      K_SLOW: begin p = 3'b010; m_good = sat_inc(m_good); m_fill = arg; end
      K_RSUM: begin p = 3'b001; m_good = sat_inc(m_good); end
      K_BAD:  m_bad = sat_inc(m_bad);
      K_UNK:  m_unk = sat_inc(m_unk);
      default: ;
    endcase
    if (k != K_NONE) begin
      e.cyc = cyc + 1; e.pulses = p; e.fill = m_fill;
      e.good = m_good; e.bad = m_bad; e.unk = m_unk;
      exp_q.push_back(e);
    end
  endtask

  task automatic reset_expect();
    exp_t e;
    m_fill = '0; m_good = '0; m_bad = '0; m_unk = '0;
    e.cyc = cyc + 1; e.pulses = 3'b000; e.fill = '0;
    e.good = '0; e.bad = '0; e.unk = '0;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [47:0] dst, input logic [15:0] etype,
                                input logic [31:0] tag, input logic [31:0] arg,
                                input int nbeats, input logic tuser,
                                input int runt_beat, input int reset_beat,
                                input kind_t k);
    logic [7:0] fb [0:63];
    for (int i = 0; i < 64; i++) fb[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 6; i++) fb[i] = dst[8*i +: 8];
    fb[12] = etype[15:8];
    fb[13] = etype[7:0];
    for (int i = 0; i < 4; i++) begin
      fb[14+i] = tag[8*i +: 8];
      fb[18+i] = arg[8*i +: 8];
    end
    for (int b = 0; b < nbeats; b++) begin
      rx.RxTdata  = {fb[4*b+3], fb[4*b+2], fb[4*b+1], fb[4*b]};
      rx.RxTkeep  = (b == runt_beat) ? 4'h7 : 4'hF;
      rx.RxTvalid = 1'b1;
      rx.RxTlast  = (b == nbeats - 1);
      rx.RxTuser  = (b == nbeats - 1) ? tuser : 1'b0;
      reset       = (b == reset_beat);
      if (b == reset_beat) reset_expect();
      if (b == nbeats - 1) push_expect(k, arg);
      @(posedge clk); #1;
    end
    rx.RxTvalid = 1'b0;
    rx.RxTlast  = 1'b0;
    rx.RxTuser  = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [63:0] got,
                              input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  logic [47:0] prev_cnt = '0;
  logic [47:0] now_cnt;
  logic [2:0]  now_pulses;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      now_cnt    = {GoodCmdCount, BadFrameCount, UnknownTagCount};
      now_pulses = {IlaTrigger, HostRequestSlowDown, HostResume};
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("[TB] FAIL missed_response want_cyc=%0d now_cyc=%0d pulses_want=%b",
                 mon_e.cyc, cyc, mon_e.pulses);
      end
      if (now_pulses != 3'b000 || now_cnt != prev_cnt) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_output cyc=%0d pulses=%b good=%h bad=%h unk=%h",
                   cyc, now_pulses, GoodCmdCount, BadFrameCount, UnknownTagCount);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || now_pulses !== mon_e.pulses ||
              HostFiFoFillAmt !== mon_e.fill || GoodCmdCount !== mon_e.good ||
              BadFrameCount !== mon_e.bad || UnknownTagCount !== mon_e.unk) begin
            miscompares++;
            $display("[TB] FAIL response got cyc=%0d p=%b fill=%h g=%h b=%h u=%h want cyc=%0d p=%b fill=%h g=%h b=%h u=%h",
                     cyc, now_pulses, HostFiFoFillAmt, GoodCmdCount, BadFrameCount,
                     UnknownTagCount, mon_e.cyc, mon_e.pulses, mon_e.fill,
                     mon_e.good, mon_e.bad, mon_e.unk);
          end
        end
      end
      prev_cnt = now_cnt;
    end
  end

  initial begin
    reset       = 1'b1;
    rx.RxTdata  = '0;
    rx.RxTkeep  = '0;
    rx.RxTvalid = 1'b0;
    rx.RxTlast  = 1'b0;
    rx.RxTuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("reset_state",
                 {13'd0, IlaTrigger, HostRequestSlowDown, HostResume,
                  HostFiFoFillAmt[15:0], GoodCmdCount, BadFrameCount, UnknownTagCount},
                 64'd0);
    check_output("reset_fill", {32'd0, HostFiFoFillAmt}, 64'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(DEF_DST_MAC, DEF_ETHER_TYPE, DEF_TAG_SLOW, 32'h0000_0200, 6, 1'b0, -1, -1, K_SLOW);
    apply_stimulus(DEF_DST_MAC, DEF_ETHER_TYPE, DEF_TAG_TRIG, 32'h1234_5678, 16, 1'b0, -1, -1, K_TRIG);
    apply_stimulus(DEF_DST_MAC, DEF_ETHER_TYPE, DEF_TAG_TRIG, 32'h0, 6, 1'b1, -1, -1, K_BAD);

    apply_stimulus(DEF_DST_MAC ^ 48'h07, DEF_ETHER_TYPE, DEF_TAG_TRIG, 32'h0, 6, 1'b0, -1, -1, K_NONE);
    check_output("dst_drop_counts", {16'd0, GoodCmdCount, BadFrameCount, UnknownTagCount},
                 {16'd0, 16'd2, 16'd1, 16'd0});
    apply_stimulus(DEF_DST_MAC, 16'h0800, DEF_TAG_SLOW, 32'h99, 6, 1'b0, -1, -1, K_NONE);
    check_output("etype_drop_counts", {16'd0, GoodCmdCount, BadFrameCount, UnknownTagCount},
                 {16'd0, 16'd2, 16'd1, 16'd0});

    apply_stimulus(DEF_DST_MAC, DEF_ETHER_TYPE, DEF_TAG_TRIG, 32'h0, 3, 1'b0, -1, -1, K_BAD);
    apply_stimulus(DEF_DST_MAC, DEF_ETHER_TYPE, DEF_TAG_RESUME, 32'h0, 6, 1'b0, -1, -1, K_RSUM);
    apply_stimulus(DEF_DST_MAC, DEF_ETHER_TYPE, DEF_TAG_TRIG, 32'h0, 6, 1'b0, 2, -1, K_BAD);

    for (int i = 0; i < 4; i++) begin
      apply_stimulus(DEF_DST_MAC, DEF_ETHER_TYPE, 32'h6463_6261, 32'h0, 6, 1'b0, -1, -1, K_UNK);
      check_output("small_unknown_sat", {62'd0, sm_unk}, (i < 3) ? 64'(i + 1) : 64'd3);
    end

    apply_stimulus(DEF_DST_MAC, DEF_ETHER_TYPE, DEF_TAG_SLOW, 32'hDEAD_BEEF, 7, 1'b0, -1, -1, K_SLOW);
    apply_stimulus(DEF_DST_MAC, DEF_ETHER_TYPE, DEF_TAG_TRIG, 32'h0, 16, 1'b0, -1, 3, K_NONE);
    apply_stimulus(DEF_DST_MAC, DEF_ETHER_TYPE, DEF_TAG_TRIG, 32'h0, 6, 1'b0, -1, -1, K_TRIG);
    check_output("small_good_after_reset", {62'd0, sm_good}, 64'd1);

    repeat (5) @(posedge clk);
    #1;
    check_output("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
